// File: rtl/rat_sseg_port_if.sv
// MCU output-bus bundle for the seven-segment port: strobed writes in, display drive out.
interface rat_sseg_port_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] SEGMENTS;
  logic [3:0] ANODES;

  modport master (
    output PORT_ID, OUT_PORT, IO_STRB,
    input  SEGMENTS, ANODES
  );

  modport slave (
    input  PORT_ID, OUT_PORT, IO_STRB,
    output SEGMENTS, ANODES
  );
endinterface

// File: rtl/rat_sseg_port.sv
// RAT MCU output peripheral: latches a 16-bit hex value and control byte from OUT writes
// and scans them onto a 4-digit common-anode display with blanking and decimal points.
module rat_sseg_port #(
  parameter logic [7:0]  PORT_LO     = 8'h81,
  parameter logic [7:0]  PORT_HI     = 8'h82,
  parameter logic [7:0]  PORT_CTRL   = 8'h83,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic            CLK,
  input  logic            RESET,
  rat_sseg_port_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      r_val;
  logic [7:0]       r_ctrl;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dig;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;

  logic [3:0] w_nib;
  logic [7:0] w_hex;
  logic       w_dp;
  logic       w_upper_zero;
  logic       w_blank;
  logic [3:0] w_an_next;
  logic [7:0] w_seg_next;

  // Strobed register writes from the MCU
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_val  <= 16'h0000;
      r_ctrl <= 8'h01;
    end else if (bus.IO_STRB) begin
      if (bus.PORT_ID == PORT_LO) begin
        r_val[7:0] <= bus.OUT_PORT;
      end else if (bus.PORT_ID == PORT_HI) begin
        r_val[15:8] <= bus.OUT_PORT;
      end else if (bus.PORT_ID == PORT_CTRL) begin
        r_ctrl <= bus.OUT_PORT;
      end
    end
  end

  // Refresh timer and digit scan; free-runs regardless of the enable bit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Select and decode the active digit
  always_comb begin
    w_nib = r_val[{r_dig, 2'b00} +: 4];
    w_dp  = r_ctrl[3'd2 + 3'(r_dig)];

    case (w_nib)
      4'h0:    w_hex = 8'hC0;
      4'h1:    w_hex = 8'hF9;
      4'h2:    w_hex = 8'hA4;
      4'h3:    w_hex = 8'hB0;
      4'h4:    w_hex = 8'h99;
      4'h5:    w_hex = 8'h92;
      4'h6:    w_hex = 8'h82;
      4'h7:    w_hex = 8'hF8;
      4'h8:    w_hex = 8'h80;
      4'h9:    w_hex = 8'h90;
      4'hA:    w_hex = 8'h88;
      4'hB:    w_hex = 8'h83;
      4'hC:    w_hex = 8'hC6;
      4'hD:    w_hex = 8'hA1;
      4'hE:    w_hex = 8'h86;
      default: w_hex = 8'h8E;
    endcase

    // Digit 0 never qualifies, so it is never blanked
    case (r_dig)
      2'd1:    w_upper_zero = (r_val[15:4]  == 12'h000);
      2'd2:    w_upper_zero = (r_val[15:8]  == 8'h00);
      2'd3:    w_upper_zero = (r_val[15:12] == 4'h0);
      default: w_upper_zero = 1'b0;
    endcase

    w_blank = r_ctrl[1] && w_upper_zero && !w_dp;
  end

  // Next display drive; disabled or blanked digits turn everything off
  always_comb begin
    w_an_next  = ~(4'b0001 << r_dig);
    w_seg_next = {w_hex[7] & ~w_dp, w_hex[6:0]};
    if (!r_ctrl[0] || w_blank) begin
      w_an_next  = 4'b1111;
      w_seg_next = 8'hFF;
    end
  end

  // Registered outputs keep the pins glitch-free
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_an  <= 4'b1110;
      r_seg <= 8'hC0;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign bus.ANODES   = r_an;
  assign bus.SEGMENTS = r_seg;

endmodule

// File: tb/tb_rat_sseg_port.sv
// Self-checking bench for rat_sseg_port with a fast refresh (4 cycles per digit).
module tb_rat_sseg_port;

  localparam int unsigned DIV = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  rat_sseg_port_if bus ();

  rat_sseg_port #(.REFRESH_DIV(DIV)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state of the peripheral
  int          m_cnt = 0;
  int          m_dig = 0;
  logic [15:0] m_val = 16'h0000;
  logic [7:0]  m_ctrl = 8'h01;

  logic [11:0] exp_q [$];

  function automatic logic [11:0] exp_out(int dig, logic [15:0] val, logic [7:0] ctrl);
    logic [15:0] up;
    logic [3:0]  nib;
    logic [7:0]  s;
    logic        dp;
    up  = val >> (4 * dig);
    nib = up[3:0];
    dp  = ctrl[2 + dig];
    if (!ctrl[0]) return 12'hFFF;
    if (ctrl[1] && dig != 0 && up == 16'h0000 && !dp) return 12'hFFF;
    s = seg_tbl[nib];
    if (dp) s[7] = 1'b0;
    return {~(4'b0001 << dig), s};
  endfunction

  // One clock: predict this edge's output, advance the model, compare 1 time unit later
  task automatic step();
    logic [11:0] want;
    logic [11:0] got;
    @(posedge CLK);
    if (RESET) begin
      exp_q.push_back({4'b1110, 8'hC0});
      m_cnt = 0; m_dig = 0; m_val = 16'h0000; m_ctrl = 8'h01;
    end else begin
      exp_q.push_back(exp_out(m_dig, m_val, m_ctrl));
      if (bus.IO_STRB) begin
        if (bus.PORT_ID == 8'h81) m_val[7:0] = bus.OUT_PORT;
        else if (bus.PORT_ID == 8'h82) m_val[15:8] = bus.OUT_PORT;
        else if (bus.PORT_ID == 8'h83) m_ctrl = bus.OUT_PORT;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    #1;
    got  = {bus.ANODES, bus.SEGMENTS};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL scan: an/seg got %h want %h at %0t", got, want, $time);
    end
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data, input logic strb);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = strb;
    step();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
  endtask

  // Step until a given anode pattern shows, then check its segments
  task automatic wait_an(input logic [3:0] an, input logic [7:0] seg, input string tag);
    int n = 0;
    while (bus.ANODES !== an && n < 20) begin
      step();
      n++;
    end
    checks++;
    assert (bus.ANODES === an) else begin
      errors++;
      $error("FAIL %s anodes: got %b want %b", tag, bus.ANODES, an);
    end
    checks++;
    assert (bus.SEGMENTS === seg) else begin
      errors++;
      $error("FAIL %s segments: got %h want %h", tag, bus.SEGMENTS, seg);
    end
  endtask

  initial begin
    int n;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;

    step();
    step();
    RESET = 1'b0;

    checks++;
    assert ({bus.ANODES, bus.SEGMENTS} === {4'b1110, 8'hC0}) else begin
      errors++;
      $error("FAIL reset: got %b/%h want 1110/c0", bus.ANODES, bus.SEGMENTS);
    end

    // Idle scan walks all four anodes showing zeros
    wait_an(4'b1101, 8'hC0, "idle_d1");
    wait_an(4'b1011, 8'hC0, "idle_d2");
    wait_an(4'b0111, 8'hC0, "idle_d3");
    wait_an(4'b1110, 8'hC0, "idle_d0");

    // Value 16'h3FA1
    wr(8'h81, 8'hA1, 1'b1);
    wr(8'h82, 8'h3F, 1'b1);
    wait_an(4'b1101, 8'h88, "val_d1");
    wait_an(4'b1011, 8'h8E, "val_d2");
    wait_an(4'b0111, 8'hB0, "val_d3");
    wait_an(4'b1110, 8'hF9, "val_d0");

    // Unstrobed and unmatched writes have no effect
    wr(8'h81, 8'hFF, 1'b0);
    wr(8'h40, 8'hFF, 1'b1);
    wr(8'h84, 8'h55, 1'b1);
    wait_an(4'b1101, 8'h88, "ign_d1");
    wait_an(4'b1110, 8'hF9, "ign_d0");

    // Leading-zero blanking of 0005
    wr(8'h81, 8'h05, 1'b1);
    wr(8'h82, 8'h00, 1'b1);
    wr(8'h83, 8'h03, 1'b1);
    step();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.ANODES === 4'b1111 && bus.SEGMENTS === 8'hFF) n++;
    end
    checks++;
    assert (n == 12) else begin
      errors++;
      $error("FAIL lzb_blank_count: got %0d want 12", n);
    end
    wait_an(4'b1110, 8'h92, "lzb_d0");

    // DP on digit 1 keeps it lit as "0."
    wr(8'h83, 8'h0B, 1'b1);
    wait_an(4'b1101, 8'h40, "dp_d1");
    wait_an(4'b1110, 8'h92, "dp_d0");

    // Global disable mid-scan, then re-enable
    step();
    wr(8'h83, 8'h00, 1'b1);
    step();
    checks++;
    assert ({bus.ANODES, bus.SEGMENTS} === {4'b1111, 8'hFF}) else begin
      errors++;
      $error("FAIL disable: got %b/%h want 1111/ff", bus.ANODES, bus.SEGMENTS);
    end
    for (int i = 0; i < 7; i++) step();
    wr(8'h82, 8'h3F, 1'b1);
    wr(8'h81, 8'hA1, 1'b1);
    wr(8'h83, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) step();

    // Asynchronous reset while digit 2 is active
    n = 0;
    while (m_dig != 2 && n < 20) begin
      step();
      n++;
    end
    step();
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    assert ({bus.ANODES, bus.SEGMENTS} === {4'b1110, 8'hC0}) else begin
      errors++;
      $error("FAIL async_reset: got %b/%h want 1110/c0", bus.ANODES, bus.SEGMENTS);
    end
    step();
    RESET = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ANODES === 4'b1110) n++;
    end
    checks++;
    assert (n == 4) else begin
      errors++;
      $error("FAIL reset_hold_d0: got %0d cycles want 4", n);
    end
    wait_an(4'b1011, 8'hC0, "post_reset_d2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
